// File: rtl/sb_pkg.sv
// rtl/sb_pkg.sv - shared types and constants for the pipeline scoreboard
package sb_pkg;
  localparam int SB_RD_W_MAX  = 8;
  localparam int SB_LAT_W_MAX = 8;

  // Slice the low LAT_W bits to get the variable-latency marker for a given counter width.
  localparam logic [SB_LAT_W_MAX-1:0] LAT_VAR = '1;

  typedef struct packed {
    logic                    we;
    logic [SB_RD_W_MAX-1:0]  rd;
    logic [SB_LAT_W_MAX-1:0] lat;
  } sb_issue_t;

  typedef struct packed {
    logic                   valid;
    logic [SB_RD_W_MAX-1:0] rd;
  } sb_wb_t;
endpackage

// File: rtl/pipeline_scoreboard_if.sv
// rtl/pipeline_scoreboard_if.sv - decode/writeback handshake bundle for the scoreboard
interface pipeline_scoreboard_if #(
  parameter int NREG         = 32,
  parameter int LAT_W        = 4,
  parameter int MAX_INFLIGHT = 8
);
  localparam int REG_W = $clog2(NREG);
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  logic             issue_valid;
  logic             issue_we;
  logic [REG_W-1:0] issue_rd;
  logic [LAT_W-1:0] issue_lat;
  logic             use_rs1;
  logic             use_rs2;
  logic [REG_W-1:0] rs1_d;
  logic [REG_W-1:0] rs2_d;
  logic             hold;
  logic             wb_valid;
  logic [REG_W-1:0] wb_rd;
  logic             flush_all;
  logic             issue_ready;
  logic             stall_d;
  logic             fwd_rs1;
  logic             fwd_rs2;
  logic [NREG-1:0]  pending;
  logic [CNT_W-1:0] inflight;
  logic             err;

  modport master (
    output issue_valid, issue_we, issue_rd, issue_lat, use_rs1, use_rs2, rs1_d, rs2_d,
    output hold, wb_valid, wb_rd, flush_all,
    input  issue_ready, stall_d, fwd_rs1, fwd_rs2, pending, inflight, err
  );

  modport slave (
    input  issue_valid, issue_we, issue_rd, issue_lat, use_rs1, use_rs2, rs1_d, rs2_d,
    input  hold, wb_valid, wb_rd, flush_all,
    output issue_ready, stall_d, fwd_rs1, fwd_rs2, pending, inflight, err
  );
endinterface

// File: rtl/sb_entry.sv
// rtl/sb_entry.sv - one destination-register countdown entry
module sb_entry
  import sb_pkg::*;
#(
  parameter int LAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             hold,
  input  logic             load,
  input  logic [LAT_W-1:0] load_lat,
  input  logic             wb_hit,
  output logic [LAT_W-1:0] cnt,
  output logic             pending,
  output logic             retiring
);
  localparam logic [LAT_W-1:0] VAR = LAT_VAR[LAT_W-1:0];
  localparam logic [LAT_W-1:0] ONE = LAT_W'(1);

  logic is_var;

  assign is_var   = (cnt == VAR);
  assign pending  = (cnt != '0);
  assign retiring = ((cnt == ONE) && !hold) || (is_var && wb_hit);

  // Load wins over retire so a same-cycle reissue of the retiring register keeps it busy.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_lat;
    end else if (retiring) begin
      cnt <= '0;
    end else if (pending && !is_var && !hold) begin
      cnt <= cnt - ONE;
    end
  end
endmodule

// File: rtl/pipeline_scoreboard.sv
// rtl/pipeline_scoreboard.sv - per-register pending tracker driving decode stall and bypass selects
module pipeline_scoreboard
  import sb_pkg::*;
#(
  parameter int NREG         = 32,
  parameter int LAT_W        = 4,
  parameter int MAX_INFLIGHT = 8,
  parameter int BYPASS       = 1
) (
  input logic                 clk,
  input logic                 rst,
  pipeline_scoreboard_if.slave sb
);
  localparam int REG_W = $clog2(NREG);
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int NSLOT = 1 << REG_W;
  localparam int RC_W  = $clog2(NSLOT + 1);
  localparam int SUM_W = ((CNT_W > RC_W) ? CNT_W : RC_W) + 1;
  localparam logic [LAT_W-1:0] ONE = LAT_W'(1);
  localparam logic [LAT_W-1:0] VAR = LAT_VAR[LAT_W-1:0];

  sb_issue_t        iss;
  sb_wb_t           wb;
  logic [LAT_W-1:0] cnt_a [NSLOT];
  logic [NSLOT-1:0] pend_v;
  logic [NSLOT-1:0] ret_v;
  logic [LAT_W-1:0] lat_eff;
  logic             fwd1, fwd2, raw1, raw2, waw, full, ready, alloc, spurious;
  logic [RC_W-1:0]  ret_cnt;
  logic [SUM_W-1:0] infl_next;
  logic [CNT_W-1:0] inflight;
  logic             err;

  assign iss = '{we: sb.issue_we, rd: SB_RD_W_MAX'(sb.issue_rd), lat: SB_LAT_W_MAX'(sb.issue_lat)};
  assign wb  = '{valid: sb.wb_valid, rd: SB_RD_W_MAX'(sb.wb_rd)};

  assign lat_eff = (iss.lat == '0) ? VAR : iss.lat[LAT_W-1:0];

  assign cnt_a[0]  = '0;
  assign pend_v[0] = 1'b0;
  assign ret_v[0]  = 1'b0;

  for (genvar r = 1; r < NSLOT; r++) begin : g_entry
    if (r < NREG) begin : g_live
      sb_entry #(.LAT_W(LAT_W)) u_entry (
        .clk      (clk),
        .rst      (rst),
        .flush    (sb.flush_all),
        .hold     (sb.hold),
        .load     (alloc && (iss.rd == SB_RD_W_MAX'(r))),
        .load_lat (lat_eff),
        .wb_hit   (wb.valid && (wb.rd == SB_RD_W_MAX'(r))),
        .cnt      (cnt_a[r]),
        .pending  (pend_v[r]),
        .retiring (ret_v[r])
      );
    end else begin : g_tie
      assign cnt_a[r]  = '0;
      assign pend_v[r] = 1'b0;
      assign ret_v[r]  = 1'b0;
    end
  end

  // Variable-latency entries never match ONE, so they are never offered on the bypass bus.
  assign fwd1 = (BYPASS != 0) && sb.use_rs1 && (cnt_a[sb.rs1_d] == ONE) && !sb.hold;
  assign fwd2 = (BYPASS != 0) && sb.use_rs2 && (cnt_a[sb.rs2_d] == ONE) && !sb.hold;
  assign raw1 = sb.use_rs1 && pend_v[sb.rs1_d] && !fwd1;
  assign raw2 = sb.use_rs2 && pend_v[sb.rs2_d] && !fwd2;

  assign waw   = iss.we && (iss.rd != '0) && pend_v[sb.issue_rd] && !ret_v[sb.issue_rd];
  assign full  = (inflight == CNT_W'(MAX_INFLIGHT)) && !(|ret_v);
  assign ready = sb.issue_valid && !raw1 && !raw2 && !waw && !full && !sb.flush_all;
  assign alloc = ready && iss.we && (iss.rd != '0);

  assign spurious = wb.valid && (cnt_a[sb.wb_rd] != VAR);

  always_comb begin
    ret_cnt = '0;
    for (int r = 0; r < NSLOT; r++) begin
      ret_cnt = ret_cnt + RC_W'(ret_v[r]);
    end
  end

  assign infl_next = SUM_W'(inflight) + SUM_W'(alloc) - SUM_W'(ret_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
      err      <= 1'b0;
    end else begin
      if (spurious) begin
        err <= 1'b1;
      end
      if (sb.flush_all) begin
        inflight <= '0;
      end else begin
        inflight <= CNT_W'(infl_next);
      end
    end
  end

  assign sb.issue_ready = ready;
  assign sb.stall_d     = raw1 || raw2;
  assign sb.fwd_rs1     = fwd1;
  assign sb.fwd_rs2     = fwd2;
  assign sb.pending     = pend_v[NREG-1:0];
  assign sb.inflight    = inflight;
  assign sb.err         = err;
endmodule

// File: tb/tb_pipeline_scoreboard.sv
// tb/tb_pipeline_scoreboard.sv - directed scoreboard bench for pipeline_scoreboard
module tb_pipeline_scoreboard;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       issue_valid, issue_we, use_rs1, use_rs2, hold, wb_valid, flush_all;
  logic [4:0] issue_rd, rs1_d, rs2_d, wb_rd;
  logic [3:0] issue_lat;

  pipeline_scoreboard_if #(.NREG(32), .LAT_W(4), .MAX_INFLIGHT(8)) if_a ();
  pipeline_scoreboard_if #(.NREG(32), .LAT_W(4), .MAX_INFLIGHT(2)) if_b ();

  pipeline_scoreboard #(.NREG(32), .LAT_W(4), .MAX_INFLIGHT(8), .BYPASS(1)) dut_a (
    .clk (clk), .rst (rst), .sb (if_a)
  );
  pipeline_scoreboard #(.NREG(32), .LAT_W(4), .MAX_INFLIGHT(2), .BYPASS(0)) dut_b (
    .clk (clk), .rst (rst), .sb (if_b)
  );

  assign if_a.issue_valid = issue_valid;  assign if_b.issue_valid = issue_valid;
  assign if_a.issue_we    = issue_we;     assign if_b.issue_we    = issue_we;
  assign if_a.issue_rd    = issue_rd;     assign if_b.issue_rd    = issue_rd;
  assign if_a.issue_lat   = issue_lat;    assign if_b.issue_lat   = issue_lat;
  assign if_a.use_rs1     = use_rs1;      assign if_b.use_rs1     = use_rs1;
  assign if_a.use_rs2     = use_rs2;      assign if_b.use_rs2     = use_rs2;
  assign if_a.rs1_d       = rs1_d;        assign if_b.rs1_d       = rs1_d;
  assign if_a.rs2_d       = rs2_d;        assign if_b.rs2_d       = rs2_d;
  assign if_a.hold        = hold;         assign if_b.hold        = hold;
  assign if_a.wb_valid    = wb_valid;     assign if_b.wb_valid    = wb_valid;
  assign if_a.wb_rd       = wb_rd;        assign if_b.wb_rd       = wb_rd;
  assign if_a.flush_all   = flush_all;    assign if_b.flush_all   = flush_all;

  typedef struct {
    string       tag;
    int unsigned val;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic int unsigned observe(string tag);
    case (tag)
      "ready_a": return 32'(if_a.issue_ready);
      "stall_a": return 32'(if_a.stall_d);
      "fwd1_a":  return 32'(if_a.fwd_rs1);
      "fwd2_a":  return 32'(if_a.fwd_rs2);
      "pend_a":  return 32'(if_a.pending);
      "infl_a":  return 32'(if_a.inflight);
      "err_a":   return 32'(if_a.err);
      "ready_b": return 32'(if_b.issue_ready);
      "stall_b": return 32'(if_b.stall_d);
      "fwd1_b":  return 32'(if_b.fwd_rs1);
      "pend_b":  return 32'(if_b.pending);
      "infl_b":  return 32'(if_b.inflight);
      "err_b":   return 32'(if_b.err);
      default:   return 32'hdead_beef;
    endcase
  endfunction

  task automatic exp_v(input string tag, input int unsigned v);
    exp_q.push_back('{tag, v});
  endtask

  task automatic settle();
    exp_t        e;
    int unsigned o;
    #5;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = observe(e.tag);
      checks++;
      assert (o === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    issue_valid = 1'b0; issue_we = 1'b0; issue_rd = '0; issue_lat = '0;
    use_rs1 = 1'b0; use_rs2 = 1'b0; rs1_d = '0; rs2_d = '0;
    hold = 1'b0; wb_valid = 1'b0; wb_rd = '0; flush_all = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [3:0] lat);
    issue_valid = 1'b1; issue_we = 1'b1; issue_rd = rd; issue_lat = lat;
  endtask

  task automatic read1(input logic [4:0] rs);
    issue_valid = 1'b1; use_rs1 = 1'b1; rs1_d = rs;
  endtask

  initial begin
    rst = 1'b1;
    next();
    next();
    // Reset state, issue_ready follows issue_valid
    next(); rst = 1'b0; issue_valid = 1'b1;
    exp_v("ready_a", 1); exp_v("stall_a", 0); exp_v("fwd1_a", 0); exp_v("pend_a", 0);
    exp_v("infl_a", 0); exp_v("err_a", 0); exp_v("ready_b", 1); exp_v("infl_b", 0);
    settle();

    // Fixed-latency chain: x5 lat 3, reader every cycle
    next(); issue(5, 3); exp_v("ready_a", 1); exp_v("ready_b", 1); settle();
    next(); read1(5); exp_v("stall_a", 1); exp_v("ready_a", 0); exp_v("infl_a", 1); exp_v("stall_b", 1); settle();
    next(); read1(5); exp_v("stall_a", 1); exp_v("stall_b", 1); settle();
    next(); read1(5); exp_v("stall_a", 0); exp_v("fwd1_a", 1); exp_v("ready_a", 1);
    exp_v("stall_b", 1); exp_v("fwd1_b", 0); settle();
    next(); read1(5); exp_v("stall_b", 0); exp_v("ready_b", 1); exp_v("infl_a", 0); exp_v("pend_a", 0); settle();

    // Variable latency under hold, then writeback
    next(); issue(7, 0); exp_v("ready_a", 1); settle();
    for (int i = 0; i < 10; i++) begin
      next(); hold = 1'b1; issue_valid = 1'b1; use_rs2 = 1'b1; rs2_d = 5'd7;
      exp_v("stall_a", 1); exp_v("fwd2_a", 0);
      if (i == 9) exp_v("pend_a", 32'h80);
      settle();
    end
    next(); wb_valid = 1'b1; wb_rd = 5'd7; issue_valid = 1'b1; use_rs2 = 1'b1; rs2_d = 5'd7;
    exp_v("stall_a", 1); exp_v("infl_a", 1); exp_v("err_a", 0); settle();
    next(); issue_valid = 1'b1; use_rs2 = 1'b1; rs2_d = 5'd7;
    exp_v("stall_a", 0); exp_v("ready_a", 1); exp_v("infl_a", 0); exp_v("err_a", 0); exp_v("stall_b", 0); settle();
    next(); wb_valid = 1'b1; wb_rd = 5'd9; settle();
    next(); exp_v("err_a", 1); exp_v("err_b", 1); exp_v("pend_a", 0); exp_v("infl_a", 0); settle();

    // WAW and same-cycle retire
    next(); issue(3, 1); exp_v("ready_a", 1); settle();
    next(); issue(3, 2); exp_v("ready_a", 1); exp_v("infl_a", 1); exp_v("ready_b", 1); settle();
    next(); issue(3, 1); exp_v("ready_a", 0); exp_v("pend_a", 32'h8); exp_v("infl_a", 1); settle();
    next(); issue(3, 1); exp_v("ready_a", 1); settle();
    next(); exp_v("pend_a", 32'h8); exp_v("infl_a", 1); settle();
    next(); exp_v("pend_a", 0); exp_v("infl_a", 0); settle();

    // Full with MAX_INFLIGHT = 2 on dut_b
    next(); issue(1, 5); exp_v("ready_b", 1); settle();
    next(); issue(2, 5); exp_v("ready_b", 1); exp_v("infl_b", 1); settle();
    next(); issue(4, 2); exp_v("ready_b", 0); exp_v("infl_b", 2); settle();
    next(); issue(4, 2); exp_v("ready_b", 0); settle();
    next(); issue(4, 2); exp_v("ready_b", 0); settle();
    next(); issue(4, 2); exp_v("ready_b", 1); settle();
    next(); exp_v("infl_b", 2); exp_v("pend_b", 32'h14); settle();
    for (int i = 0; i < 8; i++) begin
      next(); settle();
    end
    next(); exp_v("infl_a", 0); exp_v("infl_b", 0); exp_v("pend_b", 0); settle();

    // Flush with a concurrent issue
    next(); issue(10, 6); exp_v("ready_a", 1); settle();
    next(); issue(11, 0); exp_v("ready_a", 1); settle();
    next(); issue(12, 5); exp_v("ready_a", 1); settle();
    next(); flush_all = 1'b1; issue(13, 2); exp_v("infl_a", 3); exp_v("ready_a", 0); settle();
    next(); exp_v("pend_a", 0); exp_v("infl_a", 0); exp_v("err_a", 1); exp_v("pend_b", 0); settle();

    // Reset mid-countdown
    next(); issue(14, 8); exp_v("ready_a", 1); settle();
    next(); rst = 1'b1; issue(15, 0); settle();
    next(); rst = 1'b0; read1(14);
    exp_v("stall_a", 0); exp_v("fwd1_a", 0); exp_v("ready_a", 1); exp_v("pend_a", 0);
    exp_v("infl_a", 0); exp_v("err_a", 0); exp_v("err_b", 0); settle();

    // Register zero
    next(); issue(0, 3); exp_v("ready_a", 1); settle();
    next(); issue(0, 0); use_rs1 = 1'b1; use_rs2 = 1'b1;
    exp_v("stall_a", 0); exp_v("ready_a", 1); exp_v("fwd1_a", 0); exp_v("infl_a", 0); exp_v("pend_a", 0); settle();
    next(); exp_v("infl_a", 0); exp_v("pend_a", 0); exp_v("err_a", 0); settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
